// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
// Optional saturating rejected-bounce counter when DEBOUNCE_GLITCH_CNT_EN is defined.
module input_debouncer #(
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter int unsigned CNT_W         = 16,
   parameter logic        RST_LEVEL     = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_raw,
   output logic       out,
   output logic       unstable
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   typedef enum logic [0:0] {
      ST_STABLE  = 1'b0,
      ST_QUALIFY = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef DEBOUNCE_GLITCH_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

   logic [7:0] glitch_q;
   logic [7:0] glitch_d;
`endif

   state_e           state_q;
   state_e           state_d;
   logic             sync1_q;
   logic             sync2_q;
   logic             out_q;
   logic             out_d;
   logic             unstable_q;
   logic             unstable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Synchronizer and debounce state registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= RST_LEVEL;
         sync2_q    <= RST_LEVEL;
         out_q      <= RST_LEVEL;
         unstable_q <= 1'b0;
         cnt_q      <= CNT_ZERO;
         state_q    <= ST_STABLE;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         glitch_q   <= 8'd0;
`endif
      end else begin
         sync1_q    <= in_raw;
         sync2_q    <= sync1_q;
         out_q      <= out_d;
         unstable_q <= unstable_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         glitch_q   <= glitch_d;
`endif
      end
   end

   // Next-state: qualify a differing level for STABLE_CYCLES cycles, restart on any return.
   always_comb begin
      state_d    = state_q;
      out_d      = out_q;
      unstable_d = unstable_q;
      cnt_d      = cnt_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_d   = glitch_q;
`endif
      case (state_q)
         ST_STABLE: begin
            if (sync2_q != out_q) begin
               cnt_d      = CNT_ONE;
               unstable_d = 1'b1;
               state_d    = ST_QUALIFY;
            end else begin
               cnt_d      = CNT_ZERO;
               unstable_d = 1'b0;
            end
         end
         ST_QUALIFY: begin
            if (sync2_q == out_q) begin
               // Counter is always nonzero here, so this is a rejected bounce.
               cnt_d      = CNT_ZERO;
               unstable_d = 1'b0;
               state_d    = ST_STABLE;
`ifdef DEBOUNCE_GLITCH_CNT_EN
               glitch_d   = sat_inc8(glitch_q);
`endif
            end else if (cnt_q == CNT_MAX) begin
               out_d      = sync2_q;
               cnt_d      = CNT_ZERO;
               unstable_d = 1'b0;
               state_d    = ST_STABLE;
            end else begin
               cnt_d      = cnt_q + CNT_ONE;
               unstable_d = 1'b1;
            end
         end
         default: begin
            cnt_d      = CNT_ZERO;
            unstable_d = 1'b0;
            state_d    = ST_STABLE;
         end
      endcase
   end

   assign out      = out_q;
   assign unstable = unstable_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer with STABLE_CYCLES=4, RST_LEVEL=0.
module tb_input_debouncer;

   logic       clk;
   logic       rst;
   logic       in_raw;
   logic       out;
   logic       unstable;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_cnt;
`endif

   int n_checks;
   int n_pass;

   input_debouncer #(
      .STABLE_CYCLES(4),
      .CNT_W        (16),
      .RST_LEVEL    (1'b0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_raw    (in_raw),
      .out       (out),
      .unstable  (unstable)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Expected values after edges 0..5 of a clean rise.
   logic [5:0] rise_out  = 6'b100000;
   logic [5:0] rise_unst = 6'b011100;
   // Expected values after edges 0..8 of the bounce sequence.
   logic [8:0] bnc_out   = 9'b100000000;
   logic [8:0] bnc_unst  = 9'b011101100;
   // Expected unstable after edges 0..6 of the short pulse.
   logic [6:0] sp_unst   = 7'b0011100;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      in_raw   = 1'b0;
      ticks(2);
      rst = 1'b0;
      check("reset_out", {31'd0, out}, 32'd0);
      check("reset_unstable", {31'd0, unstable}, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("reset_glitch", {24'd0, glitch_cnt}, 32'd0);
`endif
      ticks(3);

      // Clean rise
      in_raw = 1'b1;
      for (int e = 0; e <= 5; e++) begin
         tick();
         check($sformatf("rise_out_e%0d", e), {31'd0, out}, {31'd0, rise_out[e]});
         check($sformatf("rise_unst_e%0d", e), {31'd0, unstable}, {31'd0, rise_unst[e]});
      end
      ticks(3);
      check("rise_hold", {31'd0, out}, 32'd1);

      // Clean fall back to 0
      in_raw = 1'b0;
      ticks(5);
      check("fall_e4_out", {31'd0, out}, 32'd1);
      tick();
      check("fall_e5_out", {31'd0, out}, 32'd0);
      ticks(3);

      // Bounce: 1,1,0 then 1 held
      for (int e = 0; e <= 8; e++) begin
         in_raw = (e == 2) ? 1'b0 : 1'b1;
         tick();
         check($sformatf("bnc_out_e%0d", e), {31'd0, out}, {31'd0, bnc_out[e]});
         check($sformatf("bnc_unst_e%0d", e), {31'd0, unstable}, {31'd0, bnc_unst[e]});
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("bnc_glitch", {24'd0, glitch_cnt}, 32'd1);
`endif
      in_raw = 1'b0;
      ticks(8);
      check("bnc_fall_out", {31'd0, out}, 32'd0);

      // Short pulse: 3 cycles high reaches the last count but must not load
      for (int e = 0; e <= 6; e++) begin
         in_raw = (e < 3) ? 1'b1 : 1'b0;
         tick();
         check($sformatf("sp_out_e%0d", e), {31'd0, out}, 32'd0);
         check($sformatf("sp_unst_e%0d", e), {31'd0, unstable}, {31'd0, sp_unst[e]});
      end
      ticks(4);
      check("sp_out_late", {31'd0, out}, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("sp_glitch", {24'd0, glitch_cnt}, 32'd2);
`endif

      // Reset mid-qualification (counter at 2 after edge 3)
      in_raw = 1'b1;
      ticks(4);
      check("rmq_unst_pre", {31'd0, unstable}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rmq_out_rst", {31'd0, out}, 32'd0);
      check("rmq_unst_rst", {31'd0, unstable}, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("rmq_glitch_rst", {24'd0, glitch_cnt}, 32'd0);
`endif
      for (int e = 1; e <= 6; e++) begin
         tick();
         check($sformatf("rmq_out_p%0d", e), {31'd0, out}, (e == 6) ? 32'd1 : 32'd0);
         if (e == 3) check("rmq_unst_p3", {31'd0, unstable}, 32'd1);
      end

      // Back to a clean low state via reset
      in_raw = 1'b0;
      rst    = 1'b1;
      ticks(2);
      rst = 1'b0;
      check("rst2_out", {31'd0, out}, 32'd0);
      ticks(3);

      // 300 rejected pulses
      for (int p = 0; p < 300; p++) begin
         in_raw = 1'b1;
         ticks(2);
         in_raw = 1'b0;
         ticks(4);
      end
      check("sat_out", {31'd0, out}, 32'd0);
      check("sat_unst", {31'd0, unstable}, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("sat_glitch", {24'd0, glitch_cnt}, 32'd255);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, 50000, consecutive synchronized cycles of a new level needed before the output follows it (legal range 2..2^CNT_W).
REQ-002 Parameter CNT_W, 16, stability counter width.
REQ-003 Parameter RST_LEVEL, 1'b0, level loaded into the synchronizer flops and the output at reset.
REQ-004 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port in_raw  input  1  asynchronous, possibly bouncing, level from a pin or switch.
REQ-007 Port out  output  1  registered, debounced, clk-synchronous level.
REQ-008 Port unstable  output  1  registered; 1 while a candidate level differs from out and is being qualified.
REQ-009 Port glitch_cnt  output  8  saturating count of rejected bounces; present only per REQ-021.

Function
REQ-010 The block SHALL pass in_raw through a two-flop synchronizer (sync1 then sync2), and only sync2 SHALL be used downstream.
REQ-011 If sync2 != out, the block SHALL increment the counter by 1 each cycle, and unstable SHALL be 1 on the following cycle.
REQ-012 If sync2 != out and the counter equals STABLE_CYCLES-1, the block SHALL load out <= sync2, clear the counter and clear unstable on the same edge.
REQ-013 If sync2 == out, the block SHALL clear the counter to 0 and clear unstable on that edge; any partial qualification SHALL be discarded.
REQ-014 Latency: with in_raw first sampled at its new value on edge 0 and held, out SHALL change on edge STABLE_CYCLES+1 and on no earlier edge.
REQ-015 Any return of sync2 to the current out level before qualification completes SHALL restart qualification from 0; out SHALL not toggle.
REQ-016 Two-state behaviour: STABLE (counter 0, unstable 0) and QUALIFY (counter > 0 or sync2 != out). Transitions SHALL follow REQ-011 to REQ-013 only.
REQ-017 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-018 out SHALL be glitch-free, with at most one transition per qualification.

Reset
REQ-019 When rst=1 at a clk edge, the block SHALL set sync1, sync2 and out to RST_LEVEL, the counter to 0, unstable to 0 and glitch_cnt to 0; rst SHALL take priority over all other updates.
REQ-020 Reset asserted mid-qualification SHALL discard the partial count. After release, qualification SHALL start afresh from the synchronized input.

Configuration
REQ-021 Macro DEBOUNCE_GLITCH_CNT_EN. When defined, the block SHALL provide port glitch_cnt, incrementing on every edge where REQ-013 clears a nonzero counter and saturating at 255. When undefined, neither the port nor its register SHALL exist, and all other behaviour SHALL be identical.

Verification (STABLE_CYCLES=4, RST_LEVEL=0)
REQ-022 Clean rise: in_raw 0->1 before edge 0 and held -> out=1 first after edge 5; unstable=1 after edges 2..4; out=0 through edge 4.
REQ-023 Bounce: in_raw 1 for 2 cycles, 0 for 1, then 1 held -> out stays 0 until 5 edges after the final rise is sampled; glitch_cnt=1 with the macro defined.
REQ-024 Short pulse: in_raw 1 for 3 cycles then 0 -> out never leaves 0; glitch_cnt increments by 1.
REQ-025 Reset mid-qualification: rst=1 for one edge while the counter is 2 with in_raw held 1 -> counter, out and unstable are 0 after that edge; out=1 first 5 edges after the first post-reset edge that samples in_raw=1.
REQ-026 Saturation: 300 rejected pulses -> glitch_cnt=255; build without the macro -> glitch_cnt port absent and out waveform identical.
